// File: rtl/umix_arr_mem_pkg.sv
// Shared types for the UM array memory responder: request bus, mode encoding,
// array descriptors and the responder's FSM states.
package umix_arr_mem_pkg;

    localparam int MEM_DEPTH = 1024;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        MEM_READ    = 2'b00,
        MEM_WRITE   = 2'b01,
        MEM_ALLOC   = 2'b10,
        MEM_ABANDON = 2'b11
    } mem_mode_t;

    typedef struct packed {
        logic              valid;
        logic [MEM_AW-1:0] base;
        logic [MEM_AW:0]   len;
    } arr_desc_t;

    typedef struct packed {
        mem_mode_t   mode;
        logic [31:0] address;
        logic [31:0] offset;
        logic [31:0] data;
    } mem_in_bus_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } arr_state_t;

endpackage

// File: rtl/umix_arr_mem_arr_desc_table.sv
// Array descriptor table: per-id base/length, lowest-free-id search and the
// legality check that turns (id, offset) into a physical word address.
module arr_desc_table
    import umix_arr_mem_pkg::*;
#(
    parameter int NUM_ARRAYS = 16,
    parameter int ID_W       = $clog2(NUM_ARRAYS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       id,
    input  logic [31:0]       offset,
    output logic              id_ok,
    output logic              legal,
    output logic [MEM_AW-1:0] phys_addr,
    output logic              free_found,
    output logic [ID_W-1:0]   free_id,
    input  logic              alloc_en,
    input  logic [MEM_AW-1:0] alloc_base,
    input  logic [MEM_AW:0]   alloc_len,
    input  logic              abandon_en
);

    arr_desc_t desc [NUM_ARRAYS];
    arr_desc_t sel;
    logic      in_range;

    // Full 32-bit compares so an out-of-range id never aliases onto a real one.
    assign in_range  = (id < 32'(NUM_ARRAYS));
    assign sel       = desc[id[ID_W-1:0]];
    assign id_ok     = in_range && sel.valid;
    assign legal     = id_ok && (offset < 32'(sel.len));
    assign phys_addr = sel.base + offset[MEM_AW-1:0];

    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int i = NUM_ARRAYS - 1; i >= 0; i--) begin
            if (!desc[i].valid) begin
                free_found = 1'b1;
                free_id    = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARRAYS; i++) begin
                desc[i] <= '0;
            end
        end else begin
            if (alloc_en) begin
                desc[free_id] <= '{valid: 1'b1, base: alloc_base, len: alloc_len};
            end
            if (abandon_en) begin
                desc[id[ID_W-1:0]].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/umix_arr_mem.sv
// UM array memory responder: flat word store, bump allocator and zero-fill FSM.
//   state   | meaning
//   ST_IDLE | accept one READ/WRITE/ALLOC/ABANDON request per cycle
//   ST_FILL | zeroing a freshly allocated array, one word per cycle; busy=1
module umix_arr_mem
    import umix_arr_mem_pkg::*;
#(
    parameter int DEPTH      = MEM_DEPTH,
    parameter int NUM_ARRAYS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_bus_t mem_in,
    output logic [31:0] mem_out,
    output logic        busy,
    output logic        fault
);

    localparam int ID_W = $clog2(NUM_ARRAYS);

    logic [31:0]       store [DEPTH];
    arr_state_t        state, state_next;
    logic [MEM_AW:0]   bump, fill_cnt;
    logic [MEM_AW-1:0] fill_addr;
    logic [ID_W-1:0]   fill_id;

    logic              id_ok, legal, free_found;
    logic [MEM_AW-1:0] phys_addr;
    logic [ID_W-1:0]   free_id, out_id;
    logic              alloc_en, abandon_en, store_we, fault_next, load_rd, load_id;
    logic [MEM_AW-1:0] store_waddr;
    logic [31:0]       store_wdata;
    logic [32:0]       alloc_end;

    assign alloc_end = {1'b0, mem_in.data} + 33'(bump);
    assign busy      = (state == ST_FILL);

    arr_desc_table #(.NUM_ARRAYS(NUM_ARRAYS), .ID_W(ID_W)) u_desc (
        .clk        (clk),
        .reset      (reset),
        .id         (mem_in.address),
        .offset     (mem_in.offset),
        .id_ok      (id_ok),
        .legal      (legal),
        .phys_addr  (phys_addr),
        .free_found (free_found),
        .free_id    (free_id),
        .alloc_en   (alloc_en),
        .alloc_base (bump[MEM_AW-1:0]),
        .alloc_len  (mem_in.data[MEM_AW:0]),
        .abandon_en (abandon_en)
    );

    always_comb begin
        state_next  = state;
        alloc_en    = 1'b0;
        abandon_en  = 1'b0;
        store_we    = 1'b0;
        store_waddr = phys_addr;
        store_wdata = mem_in.data;
        fault_next  = 1'b0;
        load_rd     = 1'b0;
        load_id     = 1'b0;
        out_id      = free_id;
        case (state)
            ST_IDLE: begin
                case (mem_in.mode)
                    MEM_READ: begin
                        load_rd    = legal;
                        fault_next = !legal;
                    end
                    MEM_WRITE: begin
                        store_we   = legal;
                        fault_next = !legal;
                    end
                    MEM_ALLOC: begin
                        if (!free_found || alloc_end > 33'(DEPTH)) begin
                            fault_next = 1'b1;
                        end else begin
                            alloc_en = 1'b1;
                            if (mem_in.data == 32'd0) begin
                                load_id = 1'b1;
                            end else begin
                                state_next = ST_FILL;
                            end
                        end
                    end
                    MEM_ABANDON: begin
                        abandon_en = id_ok && (mem_in.address != 32'd0);
                        fault_next = !abandon_en;
                    end
                    default: ;
                endcase
            end
            ST_FILL: begin
                store_we    = 1'b1;
                store_waddr = fill_addr;
                store_wdata = 32'd0;
                if (fill_cnt == (MEM_AW+1)'(1)) begin
                    state_next = ST_IDLE;
                    load_id    = 1'b1;
                    out_id     = fill_id;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bump      <= '0;
            fill_cnt  <= '0;
            fill_addr <= '0;
            fill_id   <= '0;
            mem_out   <= '0;
            fault     <= 1'b0;
        end else begin
            fault <= fault_next;
            if (load_rd) begin
                mem_out <= store[phys_addr];
            end else if (load_id) begin
                mem_out <= 32'(out_id);
            end
            if (alloc_en) begin
                bump      <= alloc_end[MEM_AW:0];
                fill_addr <= bump[MEM_AW-1:0];
                fill_cnt  <= mem_in.data[MEM_AW:0];
                fill_id   <= free_id;
            end else if (state == ST_FILL) begin
                fill_addr <= fill_addr + MEM_AW'(1);
                fill_cnt  <= fill_cnt - (MEM_AW+1)'(1);
            end
        end
    end

    // Contents are don't-care after reset, so the store carries no reset.
    always_ff @(posedge clk) begin
        if (store_we) begin
            store[store_waddr] <= store_wdata;
        end
    end

endmodule
